// File: rtl/img_csr_bank_if.sv
// ---------------------------------------------------------------------------
// axi4_lite_if : AXI4-Lite channel bundle (32-bit address/data, 4-bit strobe).
//
// Carries the five AXI4-Lite channels without clock or reset; those stay
// plain ports on the modules that use the bundle.
//   AW : awaddr, awvalid / awready
//   W  : wdata, wstrb, wvalid / wready
//   B  : bresp, bvalid / bready
//   AR : araddr, arvalid / arready
//   R  : rdata, rresp, rvalid / rready
// Modports: master (interconnect side) and slave (register bank side).
// ---------------------------------------------------------------------------
interface axi4_lite_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;

  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;

  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/img_csr_bank.sv
// ---------------------------------------------------------------------------
// img_csr_bank : AXI4-Lite register bank for the image filter blocks.
//
// CSR_CNT 32-bit registers starting at BASE_ADDR. Register i is read/write
// unless RO_MASK[i] is set, in which case reads return status_i slot i and
// writes are accepted but discarded.
//
// Parameters
//   BASE_ADDR : byte address of register 0 (4-byte aligned)
//   CSR_CNT   : number of registers, 1..64
//   RO_MASK   : bit i = 1 -> register i is read-only (status)
//   RST_VAL   : reset value of register i in bits [32*i +: 32]
//
// Ports
//   clk_i      : clock
//   rst_i      : synchronous active-high reset
//   csr_i      : AXI4-Lite slave port
//   status_i   : live values for read-only registers
//   regs_o     : control register values (read-only slots drive 0)
//   wr_pulse_o : one-cycle pulse per register updated by a write
//   sof_i      : start-of-frame, used only with CSR_SHADOW_EN
//
// Optional feature, macro CSR_SHADOW_EN: AXI accesses a staging copy and
// regs_o drives an active copy that is loaded from staging on sof_i, so a
// frame never sees a half-programmed register set.
// ---------------------------------------------------------------------------
module img_csr_bank #(
  parameter logic [31:0]           BASE_ADDR = 32'h0000_0000,
  parameter int unsigned           CSR_CNT   = 4,
  parameter logic [CSR_CNT-1:0]    RO_MASK   = '0,
  parameter logic [CSR_CNT*32-1:0] RST_VAL   = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  axi4_lite_if.slave              csr_i,
  input  logic [CSR_CNT*32-1:0]   status_i,
  output logic [CSR_CNT*32-1:0]   regs_o,
  output logic [CSR_CNT-1:0]      wr_pulse_o,
  input  logic                    sof_i
);

  localparam int unsigned IDX_W = (CSR_CNT > 1) ? $clog2(CSR_CNT) : 1;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } dec_t;

  typedef logic [CSR_CNT-1:0][31:0] bank_t;

  // Address decode: word index relative to BASE_ADDR, low two bits ignored.
  function automatic dec_t decode(input logic [31:0] addr);
    logic [31:0] off;
    dec_t        d;
    off   = addr - BASE_ADDR;
    d.hit = (addr >= BASE_ADDR) && ((off >> 2) < CSR_CNT);
    d.idx = IDX_W'(off >> 2);
    return d;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic         aw_held_q, aw_held_d;
  logic [31:0]  awaddr_q,  awaddr_d;
  logic         w_held_q,  w_held_d;
  logic [31:0]  wdata_q,   wdata_d;
  logic [3:0]   wstrb_q,   wstrb_d;
  logic         bvalid_q,  bvalid_d;
  resp_e        bresp_q,   bresp_d;

  logic         rvalid_q,  rvalid_d;
  logic [31:0]  rdata_q,   rdata_d;
  resp_e        rresp_q,   rresp_d;

  bank_t        regs_q,    regs_d;
  logic [CSR_CNT-1:0] wr_pulse_q, wr_pulse_d;

  // -------------------------------------------------------------------------
  // Write path
  // -------------------------------------------------------------------------
  logic        awready, wready;
  logic        aw_hs, w_hs, commit;
  logic [31:0] eff_awaddr, eff_wdata;
  logic [3:0]  eff_wstrb;
  dec_t        wdec;

  assign awready = !aw_held_q && !bvalid_q;
  assign wready  = !w_held_q  && !bvalid_q;

  // NOTE: every signal assigned in an always_comb gets a default at the top
  // of the block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    aw_hs = csr_i.awvalid && awready;
    w_hs  = csr_i.wvalid  && wready;

    // Address and data can each come from this cycle's handshake or from
    // an earlier one held in the flags; commit fires once both exist.
    eff_awaddr = aw_held_q ? awaddr_q : csr_i.awaddr;
    eff_wdata  = w_held_q  ? wdata_q  : csr_i.wdata;
    eff_wstrb  = w_held_q  ? wstrb_q  : csr_i.wstrb;
    commit     = (aw_hs || aw_held_q) && (w_hs || w_held_q);
    wdec       = decode(eff_awaddr);

    aw_held_d  = aw_held_q;
    awaddr_d   = awaddr_q;
    w_held_d   = w_held_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wdec.hit ? RESP_OKAY : RESP_SLVERR;
      // Read-only targets answer OKAY but neither change nor pulse.
      if (wdec.hit && !RO_MASK[wdec.idx]) begin
        for (int b = 0; b < 4; b++) begin
          if (eff_wstrb[b]) regs_d[wdec.idx][8*b +: 8] = eff_wdata[8*b +: 8];
        end
        wr_pulse_d[wdec.idx] = 1'b1;
      end
    end else begin
      if (aw_hs) begin
        aw_held_d = 1'b1;
        awaddr_d  = csr_i.awaddr;
      end
      if (w_hs) begin
        w_held_d = 1'b1;
        wdata_d  = csr_i.wdata;
        wstrb_d  = csr_i.wstrb;
      end
      // Handshakes are blocked while bvalid is high, so a B handshake and a
      // commit can never coincide.
      if (bvalid_q && csr_i.bready) begin
        bvalid_d = 1'b0;
        bresp_d  = RESP_OKAY;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read path
  // -------------------------------------------------------------------------
  logic        ar_hs;
  dec_t        rdec;
  bank_t       status_w;
  logic [31:0] rd_word;

  assign status_w = status_i;

  always_comb begin
    ar_hs = csr_i.arvalid && !rvalid_q;
    rdec  = decode(csr_i.araddr);

    // Reads sample regs_q, so a commit in the same cycle is not yet visible
    // and the pre-write value is returned.
    rd_word = '0;
    if (rdec.hit) begin
      rd_word = RO_MASK[rdec.idx] ? status_w[rdec.idx] : regs_q[rdec.idx];
    end

    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
      rresp_d  = rdec.hit ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && csr_i.rready) begin
      rvalid_d = 1'b0;
      rdata_d  = '0;
      rresp_d  = RESP_OKAY;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_held_q  <= 1'b0;
      awaddr_q   <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      // NOTE: the register array is reset in full because software relies on
      // RST_VAL; plain data buffers elsewhere would not need this.
      regs_q     <= RST_VAL;
      wr_pulse_q <= '0;
    end else begin
      aw_held_q  <= aw_held_d;
      awaddr_q   <= awaddr_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  // -------------------------------------------------------------------------
  // Control output source: staging copy directly, or a frame-aligned copy
  // -------------------------------------------------------------------------
  bank_t out_src;

`ifdef CSR_SHADOW_EN
  bank_t active_q, active_d;

  // Loading from regs_d lets a commit landing with sof_i reach the active
  // copy in the same frame.
  always_comb begin
    active_d = active_q;
    if (sof_i) active_d = regs_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) active_q <= RST_VAL;
    else       active_q <= active_d;
  end

  assign out_src = active_q;
`else
  logic unused_sof;
  assign unused_sof = sof_i;
  assign out_src    = regs_q;
`endif

  always_comb begin
    regs_o = '0;
    for (int i = 0; i < CSR_CNT; i++) begin
      if (!RO_MASK[i]) regs_o[32*i +: 32] = out_src[i];
    end
  end

  // -------------------------------------------------------------------------
  // Bus outputs
  // -------------------------------------------------------------------------
  assign csr_i.awready = awready;
  assign csr_i.wready  = wready;
  assign csr_i.bvalid  = bvalid_q;
  assign csr_i.bresp   = bresp_q;
  assign csr_i.arready = !rvalid_q;
  assign csr_i.rvalid  = rvalid_q;
  assign csr_i.rdata   = rdata_q;
  assign csr_i.rresp   = rresp_q;
  assign wr_pulse_o    = wr_pulse_q;

endmodule

// File: tb/tb_img_csr_bank.sv
// ---------------------------------------------------------------------------
// tb_img_csr_bank : self-checking bench for img_csr_bank.
//
// Four registers at 0x100, register 2 read-only, register 0 resets to 1 and
// register 3 to 0xA5A50000. A behavioural model holds the register file as a
// plain array and derives every expected response, pulse and output value.
// ---------------------------------------------------------------------------
module tb_img_csr_bank;

  localparam logic [31:0]  BASE = 32'h0000_0100;
  localparam int           CNT  = 4;
  localparam logic [3:0]   RO   = 4'b0100;
  localparam logic [127:0] RST  = {32'hA5A5_0000, 32'h0000_0000,
                                   32'h0000_0000, 32'h0000_0001};

  logic           clk = 1'b0;
  logic           rst;
  logic [127:0]   status;
  logic [127:0]   regs_o;
  logic [3:0]     wr_pulse;
  logic           sof;

  axi4_lite_if bus ();

  img_csr_bank #(
    .BASE_ADDR (BASE),
    .CSR_CNT   (CNT),
    .RO_MASK   (RO),
    .RST_VAL   (RST)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .csr_i      (bus),
    .status_i   (status),
    .regs_o     (regs_o),
    .wr_pulse_o (wr_pulse),
    .sof_i      (sof)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: staging values as written by software, active values seen by the
  // filter core (identical to staging unless the shadow feature is built).
  logic [31:0] stg [CNT];
  logic [31:0] act [CNT];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int map_idx(input logic [31:0] addr);
    longint off;
    off = longint'(addr) - longint'(BASE);
    if (off < 0 || off / 4 >= CNT) return -1;
    return int'(off / 4);
  endfunction

  function automatic logic [127:0] exp_regs();
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < CNT; i++) begin
`ifdef CSR_SHADOW_EN
      if (!RO[i]) v[32*i +: 32] = act[i];
`else
      if (!RO[i]) v[32*i +: 32] = stg[i];
`endif
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CNT; i++) begin
      stg[i] = RST[32*i +: 32];
      act[i] = RST[32*i +: 32];
    end
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb,
                             output logic [1:0] resp, output logic [3:0] pulse);
    int          i;
    logic [31:0] mask;
    i     = map_idx(addr);
    pulse = '0;
    if (i < 0) begin
      resp = 2'b10;
    end else begin
      resp = 2'b00;
      if (!RO[i]) begin
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        stg[i]   = (stg[i] & ~mask) | (data & mask);
        pulse[i] = 1'b1;
      end
    end
  endtask

  task automatic model_read(input logic [31:0] addr,
                            output logic [31:0] data, output logic [1:0] resp);
    int i;
    i = map_idx(addr);
    if (i < 0) begin
      data = '0;
      resp = 2'b10;
    end else begin
      data = RO[i] ? status[32*i +: 32] : stg[i];
      resp = 2'b00;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // AW raised aw_dly cycles and W w_dly cycles after the start; B held off
  // for b_dly cycles once bvalid appears.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly,
                           input int w_dly, input int b_dly);
    bit         aw_done, w_done, hold_ok;
    int         cyc, early;
    logic [1:0] eresp;
    logic [3:0] epulse;
    aw_done = 0; w_done = 0; hold_ok = 1; cyc = 0; early = 0;
    bus.awaddr = addr;
    bus.wdata  = data;
    bus.wstrb  = strb;
    bus.bready = 1'b0;
    while (!(aw_done && w_done) && cyc < 64) begin
      bus.awvalid = !aw_done && (cyc >= aw_dly);
      bus.wvalid  = !w_done  && (cyc >= w_dly);
      if (bus.awvalid && bus.awready) aw_done = 1;
      if (bus.wvalid  && bus.wready)  w_done  = 1;
      @(negedge clk);
      cyc++;
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      if (!(aw_done && w_done)) begin
        if (wr_pulse != '0 || bus.bvalid) early++;
        if (aw_done && bus.awready) hold_ok = 0;
        if (w_done  && bus.wready)  hold_ok = 0;
      end
    end
    check("wr_handshakes", {aw_done, w_done}, 2'b11);
    model_write(addr, data, strb, eresp, epulse);
    check("wr_no_early_commit", early, 0);
    check("wr_bvalid", bus.bvalid, 1'b1);
    check("wr_bresp", bus.bresp, eresp);
    check("wr_pulse", wr_pulse, epulse);
    check("wr_regs_o", regs_o, exp_regs());
    repeat (b_dly) begin
      @(negedge clk);
      if (bus.awready || bus.wready || !bus.bvalid || wr_pulse != '0) hold_ok = 0;
    end
    check("wr_hold", hold_ok, 1'b1);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check("wr_b_done", {bus.bvalid, wr_pulse, bus.awready, bus.wready}, 7'b0_0000_11);
  endtask

  task automatic axi_read(input logic [31:0] addr);
    logic [31:0] edata;
    logic [1:0]  eresp;
    model_read(addr, edata, eresp);
    check("rd_arready", bus.arready, 1'b1);
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("rd_rvalid", {bus.rvalid, bus.arready}, 2'b10);
    check("rd_rdata", bus.rdata, edata);
    check("rd_rresp", bus.rresp, eresp);
    @(negedge clk);
    bus.rready = 1'b0;
    check("rd_release", {bus.rvalid, bus.rdata, bus.arready}, {1'b0, 32'h0, 1'b1});
  endtask

  initial begin
    logic [31:0] addr, old_val;
    logic [1:0]  eresp;
    logic [3:0]  epulse;

    rst = 1'b1; sof = 1'b0; status = '0;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state.
    check("rst_regs_o", regs_o, exp_regs());
    check("rst_flags", {bus.bvalid, bus.rvalid, wr_pulse, bus.rdata},
          {1'b0, 1'b0, 4'h0, 32'h0});
    check("rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
    axi_read(BASE);

    // Byte-strobed write, same-cycle AW and W.
    axi_write(BASE + 32'h4, 32'hDEAD_BEEF, 4'b0101, 0, 0, 0);
    axi_read(BASE + 32'h4);

    // AW three cycles before W, then B stalled for five cycles; reverse too.
    axi_write(BASE + 32'hC, 32'h1357_9BDF, 4'hF, 0, 3, 5);
    axi_write(BASE + 32'h0, 32'h2468_ACE0, 4'b1100, 3, 0, 2);

    // Unmapped addresses above and below the window.
    axi_read(BASE + 32'd4 * CNT);
    axi_write(BASE + 32'd4 * CNT, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    axi_write(BASE - 32'h4, 32'hFFFF_FFFF, 4'hF, 1, 0, 0);

    // Read-only status register.
    status[64 +: 32] = 32'h0000_1234;
    axi_read(BASE + 32'h8);
    axi_write(BASE + 32'h8, 32'h0000_FFFF, 4'hF, 0, 0, 0);
    axi_read(BASE + 32'h8);

    // Zero strobe on a read/write register: pulse, value unchanged.
    axi_write(BASE + 32'h4, 32'hFFFF_FFFF, 4'h0, 0, 0, 0);

    // Read and commit to the same register in one cycle.
    old_val = stg[1];
    bus.awaddr = BASE + 32'h4; bus.awvalid = 1'b1;
    bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.araddr = BASE + 32'h4; bus.arvalid = 1'b1; bus.rready = 1'b1;
    bus.bready = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    model_write(BASE + 32'h4, 32'hCAFE_F00D, 4'hF, eresp, epulse);
    check("rw_same_rdata", bus.rdata, old_val);
    check("rw_same_b", {bus.bvalid, bus.bresp, wr_pulse}, {1'b1, eresp, epulse});
    check("rw_same_regs_o", regs_o, exp_regs());
    @(negedge clk);
    bus.rready = 1'b0; bus.bready = 1'b0;
    check("rw_same_done", {bus.bvalid, bus.rvalid}, 2'b00);
    axi_read(BASE + 32'h4);

    // Staged write becomes visible after start-of-frame when shadowed.
    axi_write(BASE, 32'h0000_0005, 4'hF, 0, 0, 0);
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
    for (int i = 0; i < CNT; i++) act[i] = stg[i];
    check("sof_regs_o", regs_o, exp_regs());

    // Randomized mixed traffic.
    for (int n = 0; n < 60; n++) begin
      addr = BASE - 32'h8 + 32'($urandom_range(0, 4 * CNT + 11));
      case ($urandom_range(0, 2))
        0: axi_write(addr, $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        1: axi_read(addr);
        default: begin
          status = {$urandom, $urandom, $urandom, $urandom};
          axi_read(BASE + 32'h8);
        end
      endcase
    end

    // Reset in the middle of a write: the held address must be dropped.
    bus.awaddr = BASE; bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("midrst_state", {bus.awready, bus.wready, bus.bvalid}, 3'b110);
    check("midrst_regs_o", regs_o, exp_regs());
    bus.wdata = 32'h7777_7777; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.wvalid = 1'b0;
    @(negedge clk);
    check("midrst_no_commit", {bus.bvalid, wr_pulse, regs_o}, {1'b0, 4'h0, exp_regs()});
    do_reset();
    axi_read(BASE + 32'hC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/img_csr_bank.md
# img_csr_bank

Parametrised AXI4-Lite register bank for the image-processing filter blocks, generalising the single-enable control register to CSR_CNT 32-bit registers. Each register can be a read/write control register or a read-only status register. The bank adds byte-strobe writes, independent AW/W acceptance, SLVERR on unmapped addresses, and per-register write pulses. It sits between the AXI4-Lite interconnect and a filter core's control/status signals.

## Interface
- BASE_ADDR, 32'h0000_0000: byte address of register 0; must be 4-byte aligned.
- CSR_CNT, 4: number of 32-bit registers, 1..64.
- RO_MASK, '0 (CSR_CNT bits): bit i = 1 makes register i read-only, sourced from status_i.
- RST_VAL, '0 (CSR_CNT*32 bits): reset value of register i, held in bits [32*i +: 32].
- clk_i  input  1  single clock.
- rst_i  input  1  synchronous, active-high reset.
- csr_i  axi4_lite_if.slave  32-bit addr/data, 4-bit strobe  register access port.
- status_i  input  CSR_CNT*32  live values for read-only registers; ignored for read/write registers.
- regs_o  output  CSR_CNT*32  current control register values; read-only slots drive 0.
- wr_pulse_o  output  CSR_CNT  one-cycle pulse when register i is updated by a write.
- sof_i  input  1  start-of-frame pulse; used only when CSR_SHADOW_EN is defined.

## Operation
- Word index = (addr − BASE_ADDR) >> 2; addr[1:0] ignored.
- An address is unmapped if addr < BASE_ADDR or index ≥ CSR_CNT.
- Write path:
  - Independent aw_held/w_held flags latch awaddr and wdata/wstrb at their handshakes.
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - Commit occurs in the cycle where the address (handshake or held) and the data (handshake or held) are both present.
  - On commit, each byte b with wstrb[b]=1 updates.
  - Commit clears both flags and sets bvalid.
  - bresp = 2'b10 (SLVERR) for an unmapped address, with no register change. Otherwise 2'b00.
  - A write to a read-only register is discarded, responds OKAY, and produces no pulse.
  - wstrb = 0 on a mapped read/write register still pulses wr_pulse_o with the value unchanged.
- Read path:
  - arready = !rvalid; one read outstanding.
  - At the AR handshake, rdata captures the addressed value: regs for read/write registers, status_i for read-only registers.
  - For an unmapped address, rdata = 0 and rresp = 2'b10.
  - rdata and rresp are held until the R handshake, then rdata returns to 0.
- A simultaneous read and commit to the same register returns the pre-write value.
- Read and write paths are fully independent and may complete in the same cycle.

## Timing
- Reset values:
  - registers = RST_VAL
  - bvalid, rvalid, wr_pulse_o = 0
  - rdata = 0, bresp = rresp = 2'b00
  - aw_held, w_held cleared
- Write, AW and W handshakes in cycle T: regs_o shows the new value in T+1, with wr_pulse_o[i] and bvalid high in T+1.
- AW at T, W at T+3: commit in T+3, result visible in T+4. The same holds in reverse order.
- bvalid stays high until bready. The next AW/W is accepted no earlier than the cycle after the B handshake.
- Read, AR handshake at T: rvalid and rdata valid in T+1. With rready already high, the next AR is accepted at T+2.
- Reset asserted mid-transaction drops all flags and pending responses; the master must reissue.

## Configuration
- Macro: CSR_SHADOW_EN.
- Defined:
  - Each read/write register has a staging copy, which AXI writes and reads access.
  - regs_o drives an active copy, loaded from staging when sof_i = 1.
  - If a commit and sof_i fall in the same cycle, active takes the post-write value.
  - wr_pulse_o still pulses at commit.
  - Both copies reset to RST_VAL.
- Undefined: a single copy; regs_o follows writes as described in Timing; sof_i is unused.

## Test plan
- Reset with RST_VAL[0]=32'h1 → regs_o[31:0]=1, bvalid=rvalid=0; read of BASE_ADDR returns 32'h1 with OKAY.
- AW 0x4 and W 0xDEADBEEF with wstrb 4'b0101 in the same cycle, previous value 0 → next cycle regs_o reg1 = 0x00AD00EF, wr_pulse_o[1]=1, bvalid=1, bresp=0.
- AW at T, W at T+3, bready held low 5 cycles → awready/wready stay 0 until the B handshake; a single commit occurs.
- Read of address BASE_ADDR+4*CSR_CNT → rresp=2'b10, rdata=0; a write to it → bresp=2'b10, no wr_pulse_o.
- RO_MASK bit 2 set, status_i reg2 = 0x1234 → read returns 0x1234; writing 0xFFFF gives OKAY and reg2 reads 0x1234.
- CSR_SHADOW_EN: write 0x5 to reg0 → regs_o unchanged until the sof_i pulse; 0x5 appears the cycle after sof_i.
